apb_slave_regbank: RTL and testbench

- Parametrised APB slave register bank. Successor to the fixed 5-bit-address, 32-bit-data APB slave driven by the APB master bench.
- Adds configurable depth, width and wait states, a secure register region enforced through prot, out-of-range error responses and a saturating error counter.
- Sits behind an APB master or bridge as a memory-mapped control/status block.

---
 rtl/apb_slave_regbank.sv | 115 +++++++++++
 tb/tb_apb_slave_regbank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - parametrised APB register bank with secure region, wait states and error counter
// Optional byte-lane write strobes: define APB_PSTRB_EN.
module apb_slave_regbank #(
    parameter int ADDR_WIDTH  = 5,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_CYCLES = 2,
    parameter int SECURE_REGS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [2:0]              prot,
`ifdef APB_PSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] pstrb,
`endif
    output logic                    pready,
    output logic                    pslverr,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic [7:0]              err_count
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int CW    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state;
    state_t                next_state;
    logic [CW-1:0]         wait_cnt;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [IW-1:0]         idx;
    logic [LANES-1:0]      lane_en;
    logic                  err;
    logic                  unused_prot;

    assign unused_prot = &{1'b0, prot[0], prot[2]};
    assign idx         = addr[IW-1:0];

`ifdef APB_PSTRB_EN
    assign lane_en = pstrb;
`else
    assign lane_en = '1;
`endif

    // Out-of-range words and non-secure hits on the secure window both answer with an error.
    assign err = ({1'b0, addr} >= (ADDR_WIDTH+1)'(DEPTH)) ||
                 (prot[1] && ({1'b0, addr} < (ADDR_WIDTH+1)'(SECURE_REGS)));

    assign pready  = (state == ACCESS) && psel && penable && (wait_cnt == '0);
    assign pslverr = pready && err;
    assign prdata  = (pready && !pwrite && !err) ? regs[idx] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (psel && !penable) next_state = SETUP;
            end
            SETUP: begin
                next_state = psel ? ACCESS : IDLE;
            end
            ACCESS: begin
                if (!psel) begin
                    next_state = IDLE;
                end else if (pready) begin
                    next_state = (psel && !penable) ? SETUP : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= CW'(WAIT_CYCLES);
        end else if (state == ACCESS && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (pready && pwrite && !err) begin
            for (int b = 0; b < LANES; b++) begin
                if (lane_en[b]) regs[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (pslverr && err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - scoreboard bench for apb_slave_regbank
module tb_apb_slave_regbank;

    localparam int WAITS = 2;
    localparam int DEPTH = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] pwdata = '0;
    logic [2:0]  prot = '0;
`ifdef APB_PSTRB_EN
    logic [3:0]  pstrb = '0;
`endif
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        logic [7:0]  ec;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          exp_err = 0;
    int          low_cnt = 0;

    always #5 clk = ~clk;

    apb_slave_regbank #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(DEPTH),
        .WAIT_CYCLES(WAITS), .SECURE_REGS(4)
    ) dut (
        .clk(clk), .reset(reset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .addr(addr), .pwdata(pwdata), .prot(prot),
`ifdef APB_PSTRB_EN
        .pstrb(pstrb),
`endif
        .pready(pready), .pslverr(pslverr), .prdata(prdata), .err_count(err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // The bus's first access cycle overlaps the slave's SETUP state, so each
    // transfer sees WAITS+1 pready-low access cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (!psel) low_cnt = 0;
            else if (penable && !pready) low_cnt++;
            if (pready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("prdata", prdata, e.rd);
                    check("pslverr", {31'd0, pslverr}, {31'd0, e.err});
                    check("err_count", {24'd0, err_count}, {24'd0, e.ec});
                    check("wait_cycles", low_cnt, WAITS + 1);
                end
                low_cnt = 0;
            end
        end
    end

    // Entered and left at #1 after a rising edge; leaves psel high for chaining.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d,
                        input logic [2:0] p, input logic [3:0] strb);
        exp_t       e;
        logic       er;
        logic [3:0] be;
        bit         done;
`ifdef APB_PSTRB_EN
        be = strb;
`else
        be = 4'hF | strb;
`endif
        er   = (a >= DEPTH) || (p[1] && a < 4);
        e.rd = (!w && !er) ? model[a] : 32'd0;
        e.err = er;
        e.ec  = 8'(exp_err);
        sb.push_back(e);
        if (er) exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        else if (w) for (int b = 0; b < 4; b++) if (be[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        psel = 1'b1; penable = 1'b0; pwrite = w; addr = a; pwdata = d; prot = p;
`ifdef APB_PSTRB_EN
        pstrb = strb;
`endif
        @(posedge clk); #1;
        penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < DEPTH; i++) begin
            xfer(1'b0, 5'(i), 32'd0, 3'b000, 4'hF);
            idle();
        end

        xfer(1'b1, 5'd1, 32'hDEADBEEF, 3'b000, 4'hF); idle();
        xfer(1'b0, 5'd1, 32'd0, 3'b000, 4'hF); idle();
        xfer(1'b1, 5'd1, 32'h12345678, 3'b010, 4'hF); idle();
        xfer(1'b0, 5'd1, 32'd0, 3'b000, 4'hF); idle();
        xfer(1'b0, 5'd1, 32'd0, 3'b010, 4'hF); idle();
        xfer(1'b1, 5'd10, 32'h0BADF00D, 3'b010, 4'hF); idle();
        xfer(1'b0, 5'd10, 32'd0, 3'b010, 4'hF); idle();

        xfer(1'b0, 5'd25, 32'd0, 3'b000, 4'hF); idle();
        xfer(1'b1, 5'd25, 32'hCAFEF00D, 3'b000, 4'hF); idle();
        xfer(1'b0, 5'd19, 32'd0, 3'b000, 4'hF); idle();

        xfer(1'b1, 5'd5, 32'h55555555, 3'b000, 4'hF);
        xfer(1'b1, 5'd6, 32'h66666666, 3'b000, 4'hF);
        xfer(1'b1, 5'd7, 32'h77777777, 3'b000, 4'hF);
        xfer(1'b0, 5'd5, 32'd0, 3'b000, 4'hF);
        xfer(1'b0, 5'd6, 32'd0, 3'b000, 4'hF);
        xfer(1'b0, 5'd7, 32'd0, 3'b000, 4'hF);
        idle();

        // Abort mid-ACCESS: the write to 9 must never land.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; addr = 5'd9; pwdata = 32'hFFFF0000; prot = 3'b000;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        xfer(1'b0, 5'd9, 32'd0, 3'b000, 4'hF); idle();

        // penable without a setup phase must not start a transfer.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; addr = 5'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_penable_pready", {31'd0, pready}, 32'd0);
        end
        @(posedge clk); #1;
        idle();
        xfer(1'b0, 5'd5, 32'd0, 3'b000, 4'hF); idle();

`ifdef APB_PSTRB_EN
        xfer(1'b1, 5'd8, 32'hAABBCCDD, 3'b000, 4'hF); idle();
        xfer(1'b1, 5'd8, 32'h11223344, 3'b000, 4'b0101); idle();
        xfer(1'b0, 5'd8, 32'd0, 3'b000, 4'h0); idle();
        check("pstrb_merge_model", model[8], 32'hAA22CC44);
        xfer(1'b1, 5'd8, 32'hFFFFFFFF, 3'b000, 4'h0); idle();
        xfer(1'b0, 5'd8, 32'd0, 3'b000, 4'hF); idle();
`endif

        for (int i = 0; i < 300; i++) begin
            xfer(i[0], (i % 3 == 0) ? 5'd2 : 5'd25, 32'h0, 3'b010, 4'hF);
        end
        idle();
        @(negedge clk);
        check("err_count_saturated", {24'd0, err_count}, 32'd255);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
